// File: rtl/axi_stream_fifo.sv
// AXI-stream beat buffer with a registered first-word-fall-through output stage.
// Runs cut-through, or store-and-forward with an escape for packets larger than the buffer.
module axi_stream_fifo #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int PACKET_MODE = 0
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic [DATA_WIDTH-1:0]        in_TDATA,
   input  logic [DATA_WIDTH/8-1:0]      in_TKEEP,
   input  logic                         in_TLAST,
   input  logic                         in_TVALID,
   output logic                         in_TREADY,
   output logic [DATA_WIDTH-1:0]        out_TDATA,
   output logic [DATA_WIDTH/8-1:0]      out_TKEEP,
   output logic                         out_TLAST,
   output logic                         out_TVALID,
   input  logic                         out_TREADY,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [$clog2(DEPTH+1)-1:0]   packets,
   output logic                         oversize
);

   localparam int KW = DATA_WIDTH / 8;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = DATA_WIDTH + KW + 1;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SEND,
      ST_FORCE
   } state_t;

   logic [BW-1:0] mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [LW-1:0] memCount;
   state_t        state;

   logic          push;
   logic          pop;
   logic          outFree;
   logic          loadOk;
   logic          load;
   logic          memRead;
   logic          memWrite;
   logic [LW-1:0] memPackets;
   logic [LW-1:0] levelNext;
   logic [LW-1:0] packetsNext;
   logic [BW-1:0] inBeat;
   logic [BW-1:0] headBeat;

   // The output register is refilled from memory, or straight from the sink when memory is empty.
   always_comb begin
      push        = in_TVALID && in_TREADY;
      pop         = out_TVALID && out_TREADY;
      outFree     = !out_TVALID || pop;
      memPackets  = packets - LW'(out_TVALID && out_TLAST);
      inBeat      = {in_TLAST, in_TKEEP, in_TDATA};
      headBeat    = (memCount != '0) ? mem[rdPtr] : inBeat;
      loadOk      = 1'b1;
      if (PACKET_MODE != 0)
         loadOk = (memPackets != '0) || (push && in_TLAST) ||
                  ((state == ST_FORCE) && !(out_TVALID && out_TLAST));
      load        = outFree && loadOk && ((memCount != '0) || push);
      memRead     = load && (memCount != '0);
      memWrite    = push && !(load && (memCount == '0));
      levelNext   = level + LW'(push) - LW'(pop);
      packetsNext = packets + LW'(push && in_TLAST) - LW'(pop && out_TLAST);
   end

   always_ff @(posedge ACLK) begin
      if (memWrite)
         mem[wrPtr] <= inBeat;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         memCount   <= '0;
         level      <= '0;
         packets    <= '0;
         in_TREADY  <= 1'b0;
         out_TVALID <= 1'b0;
         out_TLAST  <= 1'b0;
         out_TKEEP  <= '0;
         out_TDATA  <= '0;
      end else begin
         if (memWrite)
            wrPtr <= wrPtr + AW'(1);
         if (memRead)
            rdPtr <= rdPtr + AW'(1);
         memCount  <= memCount + LW'(memWrite) - LW'(memRead);
         level     <= levelNext;
         packets   <= packetsNext;
         in_TREADY <= (levelNext != LW'(DEPTH));
         if (load) begin
            out_TVALID                        <= 1'b1;
            {out_TLAST, out_TKEEP, out_TDATA} <= headBeat;
         end else if (pop) begin
            out_TVALID <= 1'b0;
         end
      end
   end

   // A full buffer with no complete packet can never drain in packet mode, so it is forced out.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state    <= ST_WAIT;
         oversize <= 1'b0;
      end else if (PACKET_MODE != 0) begin
         case (state)
            ST_WAIT: begin
               if (load)
                  state <= ST_SEND;
               else if ((level == LW'(DEPTH)) && (packets == '0)) begin
                  state    <= ST_FORCE;
                  oversize <= 1'b1;
               end
            end
            ST_SEND: begin
               if (pop && out_TLAST && (packetsNext == '0))
                  state <= ST_WAIT;
            end
            ST_FORCE: begin
               if (pop && out_TLAST)
                  state <= load ? ST_SEND : ST_WAIT;
            end
            default: state <= ST_WAIT;
         endcase
      end
   end

endmodule
